// File: rtl/translate_frame_ctrl.sv
// Raster-order inverse-mapping translator: each output pixel (r,c) is fetched from source (r-ty, c-tx).
// Define TRANSLATE_WRAP_EN for circular translation; the default build emits FILL for out-of-bounds sources.
module translate_frame_ctrl #(
  parameter int ROW_W = 9,
  parameter int COL_W = 9,
  parameter int PIX_W = 8,
  parameter logic [PIX_W-1:0] FILL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COL_W:0]         tx,
  input  logic [ROW_W:0]         ty,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd_en,
  output logic [ROW_W+COL_W-1:0] mem_rd_addr,
  input  logic [PIX_W-1:0]       mem_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIX_W-1:0]       out_pixel,
  output logic                   out_eol,
  output logic                   out_eof
);

  localparam int AW = ((ROW_W > COL_W) ? ROW_W : COL_W) + 2;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_WAIT, S_OUT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   r_q, r_d;
  logic [COL_W-1:0]   c_q, c_d;
  logic [COL_W:0]     tx_l_q, tx_l_d;
  logic [ROW_W:0]     ty_l_q, ty_l_d;
  logic [PIX_W-1:0]   pix_q, pix_d;

  logic signed [AW-1:0] r_ext, c_ext, tx_ext, ty_ext, sr_s, sc_s;
  logic                 in_bounds;
  logic                 last_col, last_row;

  // Widening by two bits keeps the signed difference exact for any offset.
  assign r_ext  = $signed({{(AW-ROW_W){1'b0}}, r_q});
  assign c_ext  = $signed({{(AW-COL_W){1'b0}}, c_q});
  assign ty_ext = $signed({{(AW-ROW_W-1){ty_l_q[ROW_W]}}, ty_l_q});
  assign tx_ext = $signed({{(AW-COL_W-1){tx_l_q[COL_W]}}, tx_l_q});
  assign sr_s   = r_ext - ty_ext;
  assign sc_s   = c_ext - tx_ext;

`ifdef TRANSLATE_WRAP_EN
  assign in_bounds = 1'b1;
`else
  assign in_bounds = (sr_s[AW-1:ROW_W] == '0) && (sc_s[AW-1:COL_W] == '0);
`endif

  assign last_col = &c_q;
  assign last_row = &r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      tx_l_q  <= '0;
      ty_l_q  <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      tx_l_q  <= tx_l_d;
      ty_l_q  <= ty_l_d;
      pix_q   <= pix_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    tx_l_d  = tx_l_q;
    ty_l_d  = ty_l_q;
    pix_d   = pix_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_l_d  = tx;
          ty_l_d  = ty;
          r_d     = '0;
          c_d     = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
`ifdef TRANSLATE_WRAP_EN
        state_d = S_WAIT;
`else
        if (in_bounds) begin
          state_d = S_WAIT;
        end else begin
          pix_d   = FILL;
          state_d = S_OUT;
        end
`endif
      end
      S_WAIT: begin
        pix_d   = mem_rd_data;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (last_row && last_col) begin
            state_d = S_DONE;
          end else if (last_col) begin
            c_d     = '0;
            r_d     = r_q + ROW_W'(1);
            state_d = S_CALC;
          end else begin
            c_d     = c_q + COL_W'(1);
            state_d = S_CALC;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == S_CALC) || (state_q == S_WAIT) || (state_q == S_OUT);
    done        = (state_q == S_DONE);
    mem_rd_en   = (state_q == S_CALC) && in_bounds;
    mem_rd_addr = mem_rd_en ? {sr_s[ROW_W-1:0], sc_s[COL_W-1:0]} : '0;
    out_valid   = (state_q == S_OUT);
    out_pixel   = out_valid ? pix_q : '0;
    out_eol     = out_valid && last_col;
    out_eof     = out_valid && last_col && last_row;
  end

endmodule

// File: tb/tb_translate_frame_ctrl.sv
// Directed bench for translate_frame_ctrl on a 4x4 frame; source memory holds addr+16 so FILL is distinguishable.
// Expectations follow TRANSLATE_WRAP_EN when the macro is defined.
module tb_translate_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] tx = '0;
  logic [2:0] ty = '0;
  logic       busy, done, mem_rd_en, out_valid, out_eol, out_eof;
  logic [3:0] mem_rd_addr;
  logic [7:0] mem_rd_data = '0;
  logic       out_ready = 1'b1;
  logic [7:0] out_pixel;

  int total = 0;
  int bad = 0;

  int npix, nfill, nrd, ndone, first_pix, last_pix, lat;

  typedef struct {
    logic [2:0] tx;
    logic [2:0] ty;
    int fills;
    int reads;
    int first;
    int last;
    int lat;
  } vec_t;

  vec_t vecs[6];

  translate_frame_ctrl #(.ROW_W(2), .COL_W(2), .PIX_W(8), .FILL(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start), .tx(tx), .ty(ty),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= {4'h0, mem_rd_addr} + 8'd16;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int exp_pix(input int r, input int c, input logic [2:0] ftx, input logic [2:0] fty);
    int stx, sty, sr, sc;
    stx = $signed(ftx);
    sty = $signed(fty);
    sr = r - sty;
    sc = c - stx;
`ifdef TRANSLATE_WRAP_EN
    sr = sr & 3;
    sc = sc & 3;
`else
    if (sr < 0 || sr > 3 || sc < 0 || sc > 3) return 0;
`endif
    return sr * 4 + sc + 16;
  endfunction

  task automatic run_frame(input logic [2:0] ftx, input logic [2:0] fty,
                           input int stall_at, input int rst_at, input bit mid_start);
    int cyc, nstall;
    bit fin, mid_done;
    logic [7:0] hpix;
    logic heol;
    npix = 0; nfill = 0; nrd = 0; ndone = 0; first_pix = -1; last_pix = -1; lat = -1;
    cyc = 0; nstall = 0; fin = 0; mid_done = 0; hpix = '0; heol = 1'b0;
    @(negedge clk);
    tx = ftx; ty = fty; start = 1'b1; out_ready = 1'b1;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      tx = ftx + 3'd1;
      ty = fty + 3'd1;
      out_ready = 1'b1;
      if (mem_rd_en) nrd++;
      if (done) begin
        ndone++;
        chk("busy_at_done", busy, 0);
        fin = 1;
      end
      if (out_valid && lat < 0) lat = cyc;
      if (mid_start && npix == 3 && !mid_done) begin
        start = 1'b1;
        mid_done = 1;
      end
      if (out_valid && !fin) begin
        if (rst_at == npix) begin
          rst = 1'b1;
          out_ready = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          out_ready = 1'b1;
          chk("rst_outputs_zero",
              {busy, done, out_valid, mem_rd_en, out_eol, out_eof, out_pixel, mem_rd_addr}, 0);
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) ndone++;
            chk("rst_stays_idle", busy, 0);
          end
          fin = 1;
        end else if (stall_at == npix && nstall < 5) begin
          if (nstall == 0) begin
            hpix = out_pixel;
            heol = out_eol;
          end else begin
            chk("stall_pixel_held", out_pixel, hpix);
            chk("stall_eol_held", out_eol, heol);
          end
          chk("stall_no_read", mem_rd_en, 0);
          out_ready = 1'b0;
          nstall++;
        end else begin
          chk($sformatf("pix_r%0d_c%0d", npix / 4, npix % 4), out_pixel,
              exp_pix(npix / 4, npix % 4, ftx, fty));
          chk($sformatf("eol_%0d", npix), out_eol, (npix % 4) == 3);
          chk($sformatf("eof_%0d", npix), out_eof, npix == 15);
          if (npix == 0) first_pix = out_pixel;
          last_pix = out_pixel;
          if (out_pixel == 8'h00) nfill++;
          npix++;
        end
      end else if (stall_at == npix && nstall > 0 && nstall < 5) begin
        chk("stall_valid_held", out_valid, 1);
        nstall = 5;
      end
    end
    if (!fin) chk("frame_timeout", cyc, 0);
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
`ifdef TRANSLATE_WRAP_EN
    vecs[0] = '{3'd0, 3'd0, 0, 16, 16, 31, 3};
    vecs[1] = '{3'd1, 3'd0, 0, 16, 19, 30, 3};
    vecs[2] = '{3'b111, 3'd1, 0, 16, 29, 24, 3};
    vecs[3] = '{3'b100, 3'd0, 0, 16, 16, 31, 3};
    vecs[4] = '{3'd3, 3'd3, 0, 16, 21, 16, 3};
    vecs[5] = '{3'd0, 3'b100, 0, 16, 16, 31, 3};
`else
    vecs[0] = '{3'd0, 3'd0, 0, 16, 16, 31, 3};
    vecs[1] = '{3'd1, 3'd0, 4, 12, 0, 30, 2};
    vecs[2] = '{3'b111, 3'd1, 7, 9, 0, 0, 2};
    vecs[3] = '{3'b100, 3'd0, 16, 0, 0, 0, 2};
    vecs[4] = '{3'd3, 3'd3, 15, 1, 0, 16, 2};
    vecs[5] = '{3'd0, 3'b100, 16, 0, 0, 0, 2};
`endif

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero",
        {busy, done, out_valid, mem_rd_en, out_eol, out_eof, out_pixel, mem_rd_addr}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].tx, vecs[v].ty, -1, -1, 1'b0);
      chk($sformatf("v%0d_handshakes", v), npix, 16);
      chk($sformatf("v%0d_fills", v), nfill, vecs[v].fills);
      chk($sformatf("v%0d_reads", v), nrd, vecs[v].reads);
      chk($sformatf("v%0d_first", v), first_pix, vecs[v].first);
      chk($sformatf("v%0d_last", v), last_pix, vecs[v].last);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      chk($sformatf("v%0d_done_count", v), ndone, 1);
      @(negedge clk);
      chk($sformatf("v%0d_done_single", v), done, 0);
    end

    run_frame(3'd0, 3'd0, 6, -1, 1'b0);
    chk("stall_handshakes", npix, 16);
    chk("stall_reads", nrd, 16);
    chk("stall_last", last_pix, 31);
    chk("stall_done", ndone, 1);

    run_frame(3'd0, 3'd0, -1, 9, 1'b1);
    chk("rst_mid_handshakes", npix, 9);
    chk("rst_mid_no_done", ndone, 0);

    run_frame(3'd0, 3'd0, -1, -1, 1'b0);
    chk("replay_handshakes", npix, 16);
    chk("replay_first", first_pix, 16);
    chk("replay_last", last_pix, 31);
    chk("replay_done", ndone, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
